// File: rtl/pitfall_color_encoder.sv
// RGB888 -> 6-bit palette index encoder with row-major write addressing.
// Two-stage pipeline (quantize, then index remap) with valid/ready on both sides.

module pitfall_color_encoder_quant (
  input  logic [7:0] i_c,
  output logic [1:0] o_lvl,
  output logic       o_exact
);
  // Thresholds sit midway between the palette levels 00/55/AA/FF.
  always_comb begin
    if (i_c <= 8'h2A)      o_lvl = 2'd0;
    else if (i_c <= 8'h7F) o_lvl = 2'd1;
    else if (i_c <= 8'hD4) o_lvl = 2'd2;
    else                   o_lvl = 2'd3;
  end

  assign o_exact = (i_c == 8'h00) || (i_c == 8'h55) || (i_c == 8'hAA) || (i_c == 8'hFF);
endmodule

module pitfall_color_encoder #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        Red,
  input  logic [7:0]        Green,
  input  logic [7:0]        Blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_index,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_exact,
  output logic              busy,
  output logic              done
);
  localparam int TOTAL     = WIDTH * HEIGHT;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int STAGES    = 2;
  localparam int NUM_LANES = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          r_state;
  logic [STAGES:1]                 r_vld_pipe;
  logic [CNT_W-1:0]                r_acc_cnt;
  logic [ADDR_W-1:0]               r_addr;
  logic                            r_done;
  logic [NUM_LANES-1:0][1:0]       r_lvl;
  logic                            r_ex1;
  logic [5:0]                      r_idx;
  logic                            r_ex2;

  logic [NUM_LANES-1:0][7:0]       w_chan;
  logic [NUM_LANES-1:0][1:0]       w_lvl;
  logic [NUM_LANES-1:0]            w_ex;
  logic                            w_stall;
  logic                            w_accept;
  logic                            w_out_hs;
  logic [5:0]                      w_n;
  logic [5:0]                      w_idx;
  logic                            w_ex2;

  // Lane 2 = red, 1 = green, 0 = blue.
  assign w_chan = {Red, Green, Blue};

  pitfall_color_encoder_quant u_q [NUM_LANES-1:0] (
    .i_c    (w_chan),
    .o_lvl  (w_lvl),
    .o_exact(w_ex)
  );

  assign w_stall  = r_vld_pipe[STAGES] && !out_ready;
  assign in_ready = (r_state == RUN) && (r_acc_cnt < TOTAL_CNT) && !w_stall;
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_vld_pipe[STAGES] && out_ready;

  // Palette lacks pure red (n=12); it folds onto FF,00,55 and everything above shifts down.
  always_comb begin
    w_n   = {r_lvl[1], r_lvl[2], r_lvl[0]};
    w_idx = w_n;
    w_ex2 = r_ex1;
    if (w_n == 6'd12)     w_ex2 = 1'b0;
    else if (w_n > 6'd12) w_idx = w_n - 6'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_vld_pipe <= '0;
      r_acc_cnt  <= '0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_lvl      <= '0;
      r_ex1      <= 1'b0;
      r_idx      <= '0;
      r_ex2      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_stall) begin
        r_vld_pipe <= {r_vld_pipe[1], w_accept};
        if (w_accept) begin
          r_lvl <= w_lvl;
          r_ex1 <= &w_ex;
        end
        if (r_vld_pipe[1]) begin
          r_idx <= w_idx;
          r_ex2 <= w_ex2;
        end
      end
      case (r_state)
        IDLE: begin
          // A start coinciding with done is dropped.
          if (start && !r_done) begin
            r_state   <= RUN;
            r_acc_cnt <= '0;
            r_addr    <= '0;
          end
        end
        RUN: begin
          if (w_accept) r_acc_cnt <= r_acc_cnt + 1'b1;
          if (w_out_hs) begin
            if (r_addr == LAST_ADDR) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out_index = r_idx;
  assign out_exact = r_ex2;
  assign out_addr  = r_addr;
  assign busy      = (r_state == RUN);
  assign done      = r_done;
endmodule

// File: tb/tb_pitfall_color_encoder.sv
// Directed bench for pitfall_color_encoder at default 32x32 geometry.
module tb_pitfall_color_encoder;
  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        Red = '0, Green = '0, Blue = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [5:0]        out_index;
  logic [ADDR_W-1:0] out_addr;
  logic              out_exact;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int got_idx[$];
  int got_addr[$];
  int got_ex[$];
  int done_cnt = 0;
  logic [23:0] pix_q[$];

  pitfall_color_encoder #(.WIDTH(32), .HEIGHT(32), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .Red(Red), .Green(Green), .Blue(Blue),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_addr(out_addr), .out_exact(out_exact),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Outputs sampled at negedge; out_ready is stable until the next posedge.
  always @(negedge Clk) begin
    if (Reset_n && out_valid && out_ready) begin
      got_idx.push_back(int'(out_index));
      got_addr.push_back(int'(out_addr));
      got_ex.push_back(int'(out_exact));
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic clr();
    got_idx.delete(); got_addr.delete(); got_ex.delete(); pix_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge Clk); #2;
    Reset_n = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    #10 Reset_n = 1'b1;
  endtask

  task automatic start_pulse();
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int ncyc, input int stop_outs);
    int k;
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge Clk); #1;
      out_ready = 1'b1;
      in_valid  = (k < pix_q.size());
      {Red, Green, Blue} = in_valid ? pix_q[k] : 24'h0;
      @(negedge Clk);
      if (in_valid && in_ready) k++;
      if (stop_outs > 0 && got_idx.size() >= stop_outs) break;
    end
    @(posedge Clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_index !== 6'd0) begin errors++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
    checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
    checks++; if (out_exact !== 1'b0) begin errors++; $display("FAIL reset_out_exact: got %0b expected 0", out_exact); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    // in_valid while idle must be ignored
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1 in_valid = 1'b1; {Red, Green, Blue} = 24'h123456;
      @(negedge Clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %0b expected 0", out_valid); end
    end
    @(posedge Clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_palette_sweep();
    logic [1:0] lg, lr, lb;
    int exp_i;
    do_reset(); clr();
    for (int n = 0; n < 64; n++) begin
      if (n != 12) begin
        lg = 2'(n >> 4); lr = 2'(n >> 2); lb = 2'(n);
        pix_q.push_back({8'(lr * 8'h55), 8'(lg * 8'h55), 8'(lb * 8'h55)});
      end
    end
    pix_q.push_back(24'hFFFFFF);
    start_pulse();
    feed(90, 0);
    checks++; if (got_idx.size() !== 64) begin errors++; $display("FAIL sweep_count: got %0d expected 64", got_idx.size()); end
    for (int k = 0; k < 64 && k < got_idx.size(); k++) begin
      exp_i = (k < 63) ? k : 62;
      checks++; if (got_idx[k] !== exp_i) begin errors++; $display("FAIL sweep_index[%0d]: got %0d expected %0d", k, got_idx[k], exp_i); end
      checks++; if (got_addr[k] !== k) begin errors++; $display("FAIL sweep_addr[%0d]: got %0d expected %0d", k, got_addr[k], k); end
      checks++; if (got_ex[k] !== 1) begin errors++; $display("FAIL sweep_exact[%0d]: got %0d expected 1", k, got_ex[k]); end
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL sweep_no_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_thresholds();
    logic [23:0] pix[9];
    int exp_i[9];
    int exp_e[9];
    pix   = '{24'h00002A, 24'h00002B, 24'h00007F, 24'h000080, 24'h0000D4, 24'h0000D5,
              24'hFF0000, 24'hFF0055, 24'h000000};
    exp_i = '{0, 1, 1, 2, 2, 3, 12, 12, 0};
    exp_e = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset(); clr();
    for (int k = 0; k < 9; k++) pix_q.push_back(pix[k]);
    start_pulse();
    feed(20, 0);
    checks++; if (got_idx.size() !== 9) begin errors++; $display("FAIL thr_count: got %0d expected 9", got_idx.size()); end
    for (int k = 0; k < 9 && k < got_idx.size(); k++) begin
      checks++; if (got_idx[k] !== exp_i[k]) begin errors++; $display("FAIL thr_index[%0d]: got %0d expected %0d", k, got_idx[k], exp_i[k]); end
      checks++; if (got_ex[k] !== exp_e[k]) begin errors++; $display("FAIL thr_exact[%0d]: got %0d expected %0d", k, got_ex[k], exp_e[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] pix[10];
    int exp_i[10];
    int k;
    bit have;
    logic [5:0] h_idx;
    logic [ADDR_W-1:0] h_addr;
    logic h_ex;
    pix   = '{24'h000055, 24'h550000, 24'h5500FF, 24'hAA00AA, 24'hFF0055,
              24'h005500, 24'h0055FF, 24'h5555AA, 24'hAA5555, 24'hFF5500};
    exp_i = '{1, 4, 7, 10, 12, 15, 18, 21, 24, 27};
    do_reset(); clr();
    start_pulse();
    k = 0; have = 0; h_idx = '0; h_addr = '0; h_ex = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk); #1;
      out_ready = !(c >= 5 && c < 10);
      in_valid  = (k < 10);
      {Red, Green, Blue} = (k < 10) ? pix[k] : 24'h0;
      @(negedge Clk);
      if (!out_ready && out_valid) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %0b expected 0", c, in_ready); end
        if (!have) begin
          have = 1; h_idx = out_index; h_addr = out_addr; h_ex = out_exact;
        end else begin
          checks++; if (out_index !== h_idx) begin errors++; $display("FAIL bp_hold_index c=%0d: got %0d expected %0d", c, out_index, h_idx); end
          checks++; if (out_addr !== h_addr) begin errors++; $display("FAIL bp_hold_addr c=%0d: got %0d expected %0d", c, out_addr, h_addr); end
          checks++; if (out_exact !== h_ex) begin errors++; $display("FAIL bp_hold_exact c=%0d: got %0b expected %0b", c, out_exact, h_ex); end
        end
      end
      if (in_valid && in_ready) k++;
    end
    @(posedge Clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (have !== 1'b1) begin errors++; $display("FAIL bp_stall_seen: got %0b expected 1", have); end
    checks++; if (got_idx.size() !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", got_idx.size()); end
    for (int j = 0; j < 10 && j < got_idx.size(); j++) begin
      checks++; if (got_idx[j] !== exp_i[j]) begin errors++; $display("FAIL bp_index[%0d]: got %0d expected %0d", j, got_idx[j], exp_i[j]); end
      checks++; if (got_addr[j] !== j) begin errors++; $display("FAIL bp_addr[%0d]: got %0d expected %0d", j, got_addr[j], j); end
    end
  endtask

  task automatic test_reset_mid_image();
    do_reset(); clr();
    for (int k = 0; k < 40; k++) pix_q.push_back(24'h0000FF);
    start_pulse();
    feed(80, 20);
    checks++; if (got_idx.size() < 20) begin errors++; $display("FAIL rst_mid_progress: got %0d expected >=20", got_idx.size()); end
    #3 Reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_addr !== '0) begin errors++; $display("FAIL rst_mid_out_addr: got %0d expected 0", out_addr); end
    checks++; if (out_index !== 6'd0) begin errors++; $display("FAIL rst_mid_out_index: got %0d expected 0", out_index); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %0b expected 0", in_ready); end
    #3 Reset_n = 1'b1;
    clr();
    pix_q.push_back(24'h0000FF); pix_q.push_back(24'h005500); pix_q.push_back(24'hFFFFFF);
    start_pulse();
    feed(12, 0);
    checks++; if (got_idx.size() !== 3) begin errors++; $display("FAIL rst_restart_count: got %0d expected 3", got_idx.size()); end
    if (got_idx.size() == 3) begin
      checks++; if (got_addr[0] !== 0) begin errors++; $display("FAIL rst_restart_addr0: got %0d expected 0", got_addr[0]); end
      checks++; if (got_idx[0] !== 3) begin errors++; $display("FAIL rst_restart_idx0: got %0d expected 3", got_idx[0]); end
      checks++; if (got_idx[2] !== 62) begin errors++; $display("FAIL rst_restart_idx2: got %0d expected 62", got_idx[2]); end
    end
  endtask

  task automatic test_overrun();
    int acc, post, hold;
    bit last_pend, fired;
    do_reset(); clr();
    start_pulse();
    acc = 0; post = 0; hold = 0; last_pend = 0; fired = 0;
    for (int c = 0; c < 1400; c++) begin
      @(posedge Clk); #1;
      if (last_pend && !fired) begin start = 1'b1; fired = 1; end
      else start = (c == 100);
      out_ready = !(out_valid && out_addr == 10'd1023 && hold < 3);
      in_valid = 1'b1;
      {Red, Green, Blue} = 24'h555555;
      @(negedge Clk);
      if (!out_ready) begin
        hold++;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ovr_done_early: got %0b expected 0", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovr_in_ready_full: got %0b expected 0", in_ready); end
      end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready && out_addr == 10'd1023) last_pend = 1;
      if (fired) post++;
      if (post >= 4) break;
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovr_in_ready_idle: got %0b expected 0", in_ready); end
    @(posedge Clk); #1 in_valid = 1'b0; start = 1'b0;
    checks++; if (acc !== 1024) begin errors++; $display("FAIL ovr_accepts: got %0d expected 1024", acc); end
    checks++; if (hold !== 3) begin errors++; $display("FAIL ovr_hold_cycles: got %0d expected 3", hold); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ovr_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_busy: got %0b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_out_valid: got %0b expected 0", out_valid); end
    checks++; if (got_idx.size() !== 1024) begin errors++; $display("FAIL ovr_count: got %0d expected 1024", got_idx.size()); end
    for (int k = 0; k < 1024 && k < got_idx.size(); k++) begin
      checks++; if (got_addr[k] !== k) begin errors++; $display("FAIL ovr_addr[%0d]: got %0d expected %0d", k, got_addr[k], k); end
      checks++; if (got_idx[k] !== 20) begin errors++; $display("FAIL ovr_index[%0d]: got %0d expected 20", k, got_idx[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_palette_sweep();
    test_thresholds();
    test_backpressure();
    test_reset_mid_image();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
